// File: rtl/base_ram_arbiter_pkg.sv
// Shared definitions for the base-RAM arbiter: FSM states, SRAM idle strobe
// levels and the latched request record.
package base_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD     = 2'd1,
    ST_WR     = 2'd2,
    ST_WR_REC = 2'd3
  } ram_state_t;

  localparam logic       RAM_CE_N_IDLE    = 1'b1;
  localparam logic       RAM_OE_N_IDLE    = 1'b1;
  localparam logic       RAM_WE_N_IDLE    = 1'b1;
  localparam logic [3:0] RAM_BE_N_IDLE    = 4'b1111;
  localparam logic       RAM_DATA_OE_IDLE = 1'b0;

  // Wide enough for ACCESS_CYCLES up to 15.
  localparam int TIMER_W = 4;

  typedef struct packed {
    logic        is_if;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/base_ram_arbiter_timer.sv
// access_timer: loadable down-counter; o_expire is high once the count is 0.
module access_timer
  import base_ram_arbiter_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                       r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_load_val;
    else if (i_en && (r_cnt != '0))  r_cnt <= r_cnt - 1'b1;
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/base_ram_arbiter.sv
// Single-SRAM arbiter between instruction fetch and data port; data port has
// fixed priority. Reads take ACCESS_CYCLES+1 cycles, writes ACCESS_CYCLES+2.
module base_ram_arbiter
  import base_ram_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              ram_data_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [3:0]        ram_be_n
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(ACCESS_CYCLES - 1);

  ram_state_t        r_state, w_next;
  ram_req_t          r_req;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [31:0]       r_if_rdata, r_mem_rdata;
  logic              r_if_done, r_mem_done;
  logic              w_grant, w_capture, w_wr_done, w_expire, w_timer_en;
  logic [31:0]       w_sel_addr;
  logic              w_unused_addr;

  assign w_sel_addr    = mem_req ? mem_addr : if_addr;
  assign w_unused_addr = ^{if_addr, mem_addr};
  assign w_timer_en    = (r_state == ST_RD) || (r_state == ST_WR);

  access_timer #(.W(TIMER_W)) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_grant),
    .i_load_val (LOAD_VAL),
    .i_en       (w_timer_en),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    w_wr_done   = 1'b0;
    ram_ce_n    = RAM_CE_N_IDLE;
    ram_oe_n    = RAM_OE_N_IDLE;
    ram_we_n    = RAM_WE_N_IDLE;
    ram_be_n    = RAM_BE_N_IDLE;
    ram_data_oe = RAM_DATA_OE_IDLE;
    case (r_state)
      ST_IDLE: begin
        // The done cycle itself never grants, so done and grant stay apart.
        if (!r_if_done && !r_mem_done && (mem_req || if_req)) begin
          w_grant = 1'b1;
          w_next  = (mem_req && mem_we) ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        ram_be_n = ~r_req.be;
        if (w_expire) begin
          w_capture = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_WR: begin
        ram_ce_n    = 1'b0;
        ram_we_n    = 1'b0;
        ram_data_oe = 1'b1;
        ram_be_n    = ~r_req.be;
        if (w_expire) w_next = ST_WR_REC;
      end
      ST_WR_REC: begin
        // Hold the bus one more cycle so data outlives the we_n rising edge.
        ram_data_oe = 1'b1;
        w_wr_done   = 1'b1;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= '0;
      r_ram_addr  <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
    end else begin
      r_if_done  <= w_capture & r_req.is_if;
      r_mem_done <= (w_capture & ~r_req.is_if) | w_wr_done;
      if (w_capture) begin
        if (r_req.is_if) r_if_rdata  <= ram_rdata;
        else             r_mem_rdata <= ram_rdata;
      end
      if (w_grant) begin
        r_req.is_if <= ~mem_req;
        r_req.we    <= mem_req & mem_we;
        r_req.be    <= mem_req ? mem_be : 4'hF;
        r_ram_addr  <= w_sel_addr[ADDR_W+1:2];
        if (mem_req) r_req.wdata <= mem_wdata;
      end
    end
  end

  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign if_done   = r_if_done;
  assign mem_done  = r_mem_done;
  assign stall_if  = if_req & ~r_if_done;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_req.wdata;

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Bench for base_ram_arbiter: directed scenarios plus random traffic against
// a transaction-level model; a second instance runs with ACCESS_CYCLES=1.
module tb_base_ram_arbiter;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst, if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [3:0]  mem_be;
  logic [31:0] if_rdata, mem_rdata, ram_wdata;
  logic        if_done, mem_done, stall_if, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
  logic [3:0]  ram_be_n;
  logic [19:0] ram_addr;

  logic        b_rst, b_if_req, b_mem_req, b_mem_we;
  logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata, b_ram_rdata;
  logic [3:0]  b_mem_be;
  logic [31:0] b_if_rdata, b_mem_rdata, b_ram_wdata;
  logic        b_if_done, b_mem_done, b_stall_if, b_ram_data_oe, b_ram_ce_n, b_ram_oe_n, b_ram_we_n;
  logic [3:0]  b_ram_be_n;
  logic [19:0] b_ram_addr;

  always #5 clk = ~clk;

  base_ram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(20)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .stall_if(stall_if), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_data_oe(ram_data_oe),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_be_n(ram_be_n)
  );

  base_ram_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(20)) u_dut1 (
    .clk(clk), .rst(b_rst), .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
    .if_done(b_if_done), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .mem_done(b_mem_done), .stall_if(b_stall_if), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .ram_data_oe(b_ram_data_oe),
    .ram_ce_n(b_ram_ce_n), .ram_oe_n(b_ram_oe_n), .ram_we_n(b_ram_we_n), .ram_be_n(b_ram_be_n)
  );

  int n_chk = 0, n_pass = 0, cyc = 0, b_last = -1, b_pulses = 0;

  // Model: m_t counts cycles since grant (0 = no access in flight).
  int          m_t;
  logic        m_is_if, m_we, m_if_done, m_mem_done;
  logic [3:0]  m_be;
  logic [19:0] m_addr;
  logic [31:0] m_wdata, m_if_rdata, m_mem_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_step();
    logic        blocked;
    logic [31:0] a;
    blocked    = m_if_done | m_mem_done;
    m_if_done  = 1'b0;
    m_mem_done = 1'b0;
    if (rst) begin
      m_t = 0; m_is_if = 1'b0; m_we = 1'b0; m_be = 4'h0; m_addr = '0;
      m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
    end else if (m_t > 0) begin
      if (!m_we && m_t == AC) begin
        if (m_is_if) begin m_if_rdata = ram_rdata; m_if_done = 1'b1; end
        else begin m_mem_rdata = ram_rdata; m_mem_done = 1'b1; end
        m_t = 0;
      end else if (m_we && m_t == AC + 1) begin
        m_mem_done = 1'b1;
        m_t = 0;
      end else m_t++;
    end else if (!blocked && (mem_req || if_req)) begin
      m_t     = 1;
      m_is_if = !mem_req;
      m_we    = mem_req & mem_we;
      m_be    = mem_req ? mem_be : 4'hF;
      a       = mem_req ? mem_addr : if_addr;
      m_addr  = a[21:2];
      if (mem_req) m_wdata = mem_wdata;
    end
  endtask

  task automatic compare();
    logic       strobe;
    logic [3:0] ebe;
    strobe = (m_t >= 1) && (m_t <= AC);
    ebe    = strobe ? ~m_be : 4'hF;
    chk("ce_n", ram_ce_n, !strobe);
    chk("oe_n", ram_oe_n, !(strobe && !m_we));
    chk("we_n", ram_we_n, !(strobe && m_we));
    chk("data_oe", ram_data_oe, m_we && m_t >= 1 && m_t <= AC + 1);
    chk("be_n", ram_be_n, ebe);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_wdata", ram_wdata, m_wdata);
    chk("if_done", if_done, m_if_done);
    chk("mem_done", mem_done, m_mem_done);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("mem_rdata", mem_rdata, m_mem_rdata);
    chk("stall_if", stall_if, if_req & ~m_if_done);
    chk("contention", !ram_oe_n && ram_data_oe, 0);
    chk("contention1", !b_ram_oe_n && b_ram_data_oe, 0);
    chk("stall_if1", b_stall_if, b_if_req & ~b_if_done);
    if (b_if_done === 1'b1) begin
      if (b_last >= 0) chk("ac1_gap", 32'(cyc - b_last), 3);
      b_last = cyc;
      b_pulses++;
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    b_ram_rdata = $urandom;
    compare();
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_be = 4'h0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    b_rst = 1'b1; b_if_req = 1'b0; b_mem_req = 1'b0; b_mem_we = 1'b0; b_mem_be = 4'h0;
    b_if_addr = 32'h0000_1234; b_mem_addr = '0; b_mem_wdata = '0; b_ram_rdata = '0;
    m_if_done = 1'b0; m_mem_done = 1'b0;
    tick();
    chk("rst_ce_n", ram_ce_n, 1); chk("rst_be_n", ram_be_n, 4'hF);
    chk("rst_doe", ram_data_oe, 0); chk("rst_if_rdata", if_rdata, 0);
    rst = 1'b0; b_rst = 1'b0; b_if_req = 1'b1;

    // Fetch
    if_req = 1'b1; if_addr = 32'h8000_0010; ram_rdata = 32'h2408_0001;
    tick(); chk("f_addr", ram_addr, 20'h00004); chk("f_oe_n", ram_oe_n, 0); chk("f_be_n", ram_be_n, 4'h0);
    tick(); chk("f_done_early", if_done, 0);
    tick(); chk("f_done", if_done, 1); chk("f_rdata", if_rdata, 32'h2408_0001); chk("f_stall", stall_if, 0);
    if_req = 1'b0; tick();

    // Store; inputs change while busy and must be ignored
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 32'h8000_0020; mem_wdata = 32'hDEAD_BEEF;
    tick(); chk("s_be_n", ram_be_n, 4'b1100); chk("s_we_n1", ram_we_n, 0); chk("s_addr", ram_addr, 20'h00008);
    mem_addr = 32'hFFFF_FFFC; mem_wdata = 32'h0; mem_be = 4'hF; mem_we = 1'b0;
    tick(); chk("s_we_n2", ram_we_n, 0); chk("s_be_n2", ram_be_n, 4'b1100);
    tick(); chk("s_rec_we_n", ram_we_n, 1); chk("s_rec_doe", ram_data_oe, 1);
    chk("s_rec_wdata", ram_wdata, 32'hDEAD_BEEF); chk("s_rec_done", mem_done, 0);
    tick(); chk("s_done", mem_done, 1); chk("s_doe_off", ram_data_oe, 0);
    mem_req = 1'b0; tick();

    // Simultaneous load and fetch: data port first
    if_req = 1'b1; if_addr = 32'h0000_0200; mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF;
    mem_addr = 32'h0000_0100; ram_rdata = 32'h1111_1111;
    tick(); chk("p_stall1", stall_if, 1); chk("p_addr", ram_addr, 20'h00040);
    tick(); chk("p_stall2", stall_if, 1);
    tick(); chk("p_mdone", mem_done, 1); chk("p_mrdata", mem_rdata, 32'h1111_1111); chk("p_stall3", stall_if, 1);
    mem_req = 1'b0; ram_rdata = 32'h2222_2222;
    tick(); chk("p_gap_ce_n", ram_ce_n, 1); chk("p_stall4", stall_if, 1);
    tick(); chk("p_f_ce_n", ram_ce_n, 0); chk("p_f_addr", ram_addr, 20'h00080);
    tick();
    tick(); chk("p_fdone", if_done, 1); chk("p_frdata", if_rdata, 32'h2222_2222);
    if_req = 1'b0; tick();

    // Reset during the second write cycle
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'hF; mem_addr = 32'h0000_0040; mem_wdata = 32'h1234_5678;
    tick(); tick(); chk("r_we_n_pre", ram_we_n, 0);
    rst = 1'b1;
    tick(); chk("r_we_n", ram_we_n, 1); chk("r_doe", ram_data_oe, 0);
    chk("r_wdata", ram_wdata, 0); chk("r_addr", ram_addr, 0); chk("r_mrdata", mem_rdata, 0);
    rst = 1'b0; mem_req = 1'b0;
    repeat (4) begin tick(); chk("r_no_done", mem_done, 0); end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      else if (m_if_done) if_req = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 99) == 0) if_req = 1'b0;
      if (!mem_req) mem_req = ($urandom_range(0, 2) == 0);
      else if (m_mem_done) mem_req = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 99) == 0) mem_req = 1'b0;
      mem_we = 1'($urandom_range(0, 1)); mem_be = 4'($urandom_range(0, 15));
      if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom; ram_rdata = $urandom;
      tick();
    end

    chk("ac1_pulses", b_pulses >= 10, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/base_ram_arbiter.md
BASE_RAM_ARBITER -- requirements
Module: base_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ACCESS_CYCLES, default 2, giving the SRAM strobe-active cycles per access (legal 1..15).
REQ-002 The block SHALL have parameter ADDR_W, default 20, giving the SRAM word-address width.
REQ-003 The block SHALL run on one clock and use a synchronous, active-high reset.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port if_req, input, 1: instruction-fetch request; held high until if_done.
REQ-007 Port if_addr, input, 32: fetch byte address.
REQ-008 Port if_rdata, output, 32: fetched instruction word.
REQ-009 Port if_done, output, 1: one-cycle pulse; if_rdata is valid this cycle.
REQ-010 Port mem_req, input, 1: data request; held high until mem_done.
REQ-011 Port mem_we, input, 1: 1 = store, 0 = load.
REQ-012 Port mem_be, input, 4: byte enables, active high.
REQ-013 Port mem_addr, input, 32: data byte address.
REQ-014 Port mem_wdata, input, 32: store data.
REQ-015 Port mem_rdata, output, 32: load data.
REQ-016 Port mem_done, output, 1: one-cycle completion pulse.
REQ-017 Port stall_if, output, 1: high while if_req is pending and not completing this cycle.
REQ-018 Port ram_addr, output, ADDR_W: SRAM word address, taken from byte address bits [ADDR_W+1:2].
REQ-019 Port ram_wdata, output, 32: SRAM write data.
REQ-020 Port ram_rdata, input, 32: SRAM read data.
REQ-021 Port ram_data_oe, output, 1: tristate drive enable for the SRAM data bus.
REQ-022 Port ram_ce_n, output, 1: SRAM chip enable, active low.
REQ-023 Port ram_oe_n, output, 1: SRAM output enable, active low.
REQ-024 Port ram_we_n, output, 1: SRAM write enable, active low.
REQ-025 Port ram_be_n, output, 4: SRAM byte enables, active low.

Function
REQ-026 The FSM SHALL have the states IDLE, RD, WR and WR_REC.
REQ-027 In IDLE with mem_req=1, the block SHALL grant the data port (fixed priority over fetch), latching address, we, be and wdata; next state is WR if mem_we=1, else RD.
REQ-028 In IDLE with only if_req=1, the block SHALL grant fetch, latch if_addr, and go to RD with ram_be_n=0000.
REQ-029 RD SHALL hold ce_n=0 and oe_n=0 for ACCESS_CYCLES cycles, then capture ram_rdata on the last cycle into the granted port's rdata register, pulse that port's done next cycle, and return to IDLE.
REQ-030 WR SHALL hold ce_n=0, we_n=0, ram_data_oe=1 and ram_be_n=~be for ACCESS_CYCLES cycles, then go to WR_REC.
REQ-031 WR_REC SHALL last 1 cycle with we_n=1 and ce_n=1 while keeping ram_data_oe=1 and ram_wdata stable, then pulse mem_done and return to IDLE.
REQ-032 The cycle count for a read SHALL be exactly ACCESS_CYCLES+1 from grant to done pulse; for a write, ACCESS_CYCLES+2.
REQ-033 A done pulse and a new grant SHALL NOT occur in the same cycle; a new grant is taken earliest in the cycle after done.
REQ-034 Requests changing while busy SHALL be ignored; the latched values govern the access.
REQ-035 If requests drop while busy, the access SHALL complete and no done pulse SHALL be suppressed.
REQ-036 if_rdata and mem_rdata SHALL hold their last value until overwritten by a new completed read.
REQ-037 stall_if SHALL equal if_req & ~if_done (combinational).
REQ-038 Outside active phases, outputs SHALL idle at ce_n=oe_n=we_n=1, ram_be_n=1111 and ram_data_oe=0.
REQ-039 oe_n=0 and ram_data_oe=1 SHALL never be asserted together.

Reset
REQ-040 On rst, in the same edge and regardless of state (mid-access included), the block SHALL go to IDLE, set all strobes inactive as in REQ-038, set if_done=mem_done=0, clear if_rdata, mem_rdata, ram_addr and ram_wdata to 0, and discard the aborted access with no done pulse.

Structure
REQ-041 FSM state encodings and the SRAM idle strobe constants SHALL reside in the shared CPU package.
REQ-042 The wait counter SHALL be a sub-module named access_timer (load, count-down, expire flag).

Verification
REQ-043 Fetch with if_addr=0x8000_0010 and ram_rdata=0x2408_0001 SHALL give ram_addr=0x00004, if_done at cycle 3 and if_rdata=0x2408_0001.
REQ-044 A store with addr=0x8000_0020, be=0011 and wdata=0xDEAD_BEEF SHALL show ram_be_n=1100 and we_n low for 2 cycles, 1 recovery cycle with data driven, and mem_done at cycle 4.
REQ-045 With if_req and mem_req (load) raised together, mem_done SHALL come first, then the fetch is granted the cycle after, and stall_if stays high throughout.
REQ-046 With rst asserted in the 2nd WR cycle, we_n SHALL be 1 and ram_data_oe 0 at the next edge, with no mem_done.
REQ-047 With ACCESS_CYCLES=1, back-to-back fetches SHALL give if_done every 3 cycles.
REQ-048 A bus-contention checker SHALL flag any cycle with oe_n=0 and ram_data_oe=1.
